// File: rtl/alu_pkg.sv
// Shared definitions for the ALU engine, the result latch and the controller:
// opcodes, flag bit positions, multiply step count and FSM encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;

    localparam int MUL_STEPS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_engine_mul.sv
// Iterative shift-add multiplier: one partial product per clock, LSB-first on
// the multiplier, with a down-counter terminating after MUL_STEPS steps.
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        finish   = 1'b0;
        product  = acc_q;
        if (go) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            acc_d    = '0;
            cnt_d    = CNT_LAST;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Final step: the owner latches the post-step accumulator this edge.
            product  = acc_d;
            if (cnt_q == '0) begin
                finish   = 1'b1;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/alu_engine.sv
// Multi-cycle ALU: operand registers, single-cycle datapath, flag generation
// and the top sequencing FSM driving the result latch's grab via done.
//
//   state   | meaning
//   ST_IDLE | accepting start; non-MUL ops complete at the start edge
//   ST_MUL  | shift-add multiply in progress, start ignored
module alu_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic [2:0]           opcode,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   alu_result,
    output logic [2:0]           flags_out,
    output logic                 busy,
    output logic                 done
);

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               done_q, done_d;
    state_t             state_q, state_d;

    logic [WIDTH:0]     low;
    logic               mul_go, mul_finish;
    logic [2*WIDTH-1:0] mul_product;

    shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clock     (clock),
        .reset     (reset),
        .go        (mul_go),
        .mcand_in  (a_q),
        .mplier_in (b_q),
        .finish    (mul_finish),
        .product   (mul_product)
    );

    // low[WIDTH] carries carry/borrow/shifted-out bit for the single-cycle ops.
    always_comb begin
        case (opcode)
            OP_ADD:  low = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  low = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  low = {1'b0, a_q & b_q};
            OP_OR:   low = {1'b0, a_q | b_q};
            OP_XOR:  low = {1'b0, a_q ^ b_q};
            OP_SHL:  low = {a_q[WIDTH-1], a_q[WIDTH-2:0], 1'b0};
            OP_SHR:  low = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
            default: low = '0;
        endcase
    end

    always_comb begin
        a_d      = load_a ? data_in : a_q;
        b_d      = load_b ? data_in : b_q;
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mul_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        mul_go  = 1'b1;
                        state_d = ST_MUL;
                    end else begin
                        result_d            = {{WIDTH{1'b0}}, low[WIDTH-1:0]};
                        flags_d[FLAG_NEG]   = low[WIDTH-1];
                        flags_d[FLAG_CARRY] = low[WIDTH];
                        flags_d[FLAG_ZERO]  = (low[WIDTH-1:0] == '0);
                        done_d              = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_finish) begin
                    result_d            = mul_product;
                    flags_d[FLAG_NEG]   = mul_product[2*WIDTH-1];
                    flags_d[FLAG_CARRY] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_ZERO]  = (mul_product == '0);
                    done_d              = 1'b1;
                    state_d             = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            state_q  <= state_d;
        end
    end

    assign alu_result = result_q;
    assign flags_out  = flags_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_engine.sv
// Self-checking bench for alu_engine: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_alu_engine;
    import alu_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  data_in;
    logic        load_a;
    logic        load_b;
    logic [2:0]  opcode;
    logic        start;
    logic [15:0] alu_result;
    logic [2:0]  flags_out;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    alu_engine #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_a     (load_a),
        .load_b     (load_b),
        .opcode     (opcode),
        .start      (start),
        .alu_result (alu_result),
        .flags_out  (flags_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns {neg, carry, zero, result[15:0]} from plain arithmetic.
    function automatic logic [18:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, r;
        logic c, n;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        r  = 0;
        case (op)
            OP_ADD: begin r = (ai + bi) % 256; c = (ai + bi) > 255; end
            OP_SUB: begin r = (ai - bi + 256) % 256; c = ai < bi; end
            OP_AND: r = int'(a & b);
            OP_OR:  r = int'(a | b);
            OP_XOR: r = int'(a ^ b);
            OP_SHL: begin r = (ai * 2) % 256; c = ai >= 128; end
            OP_SHR: begin r = ai / 2; c = (ai % 2) == 1; end
            default: begin r = ai * bi; c = r > 255; end
        endcase
        n = (op == OP_MUL) ? (r >= 32768) : (r >= 128);
        return {n, c, (r == 0), 16'(r)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        data_in = a; load_a = 1'b1; load_b = 1'b0;
        @(negedge clock);
        data_in = b; load_a = 1'b0; load_b = 1'b1;
        @(negedge clock);
        load_b = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit do_load, input string tag);
        logic [18:0] exp_v;
        int lat, bcnt;
        exp_v = model(op, a, b);
        if (do_load) load_ops(a, b);
        @(negedge clock);
        opcode = op; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; opcode = 3'($urandom);
        wait_done(lat, bcnt);
        check({tag, "_lat"},  lat, (op == OP_MUL) ? 9 : 1);
        check({tag, "_res"},  {13'b0, flags_out, alu_result}, {13'b0, exp_v});
        check({tag, "_busy"}, bcnt, (op == OP_MUL) ? 8 : 0);
        check({tag, "_bd"},   {30'b0, busy, done}, 32'b01);
        @(posedge clock); #1;
        check({tag, "_pulse"}, {31'b0, done}, 32'b0);
    endtask

    initial begin
        int lat, bcnt, dcnt;
        reset = 1'b1; data_in = '0; load_a = 1'b0; load_b = 1'b0; opcode = '0; start = 1'b0;
        #2 reset = 1'b0;
        #1 check("reset_outs", {11'b0, alu_result, flags_out, busy, done}, 32'b0);
        @(negedge clock);
        reset = 1'b1;

        do_op(OP_ADD, 8'h00, 8'h00, 1'b1, "add_zero");
        check("add_zero_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b001, 16'h0000});
        do_op(OP_ADD, 8'hF0, 8'h20, 1'b1, "add_carry");
        check("add_carry_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b010, 16'h0010});
        do_op(OP_SUB, 8'h10, 8'h20, 1'b1, "sub_borrow");
        check("sub_borrow_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b110, 16'h00F0});
        do_op(OP_SHL, 8'h81, 8'h00, 1'b1, "shl");
        check("shl_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b010, 16'h0002});
        do_op(OP_SHR, 8'h81, 8'h00, 1'b1, "shr");
        check("shr_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b010, 16'h0040});
        do_op(OP_XOR, 8'h5A, 8'h5A, 1'b1, "xor_zero");
        check("xor_zero_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b001, 16'h0000});

        // MUL FFxFF with an ignored start and an operand load while busy
        load_ops(8'hFF, 8'hFF);
        @(negedge clock);
        opcode = OP_MUL; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clock);
            start   = (lat == 3);
            opcode  = OP_ADD;
            load_a  = (lat == 5);
            data_in = 8'h03;
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0; load_a = 1'b0;
        check("mul_ff_lat", lat, 9);
        check("mul_ff_busy", bcnt, 8);
        check("mul_ff_res", {13'b0, flags_out, alu_result}, {13'b0, 3'b110, 16'hFE01});
        @(posedge clock); #1;
        check("mul_ff_pulse", {31'b0, done}, 32'b0);
        // The load during busy takes effect on the next operation only
        do_op(OP_MUL, 8'h03, 8'hFF, 1'b0, "mul_next");
        check("mul_next_const", {13'b0, flags_out, alu_result}, {13'b0, 3'b010, 16'h02FD});

        // Reset mid-MUL aborts with no done afterwards
        load_ops(8'h12, 8'h34);
        @(negedge clock);
        opcode = OP_MUL; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #3 reset = 1'b0;
        #1 check("rst_mid_mul", {11'b0, alu_result, flags_out, busy, done}, 32'b0);
        @(negedge clock);
        reset = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (done || busy) dcnt++;
        end
        check("rst_no_done", dcnt, 0);

        // Back-to-back: AND started during the done cycle of an OR
        load_ops(8'h0F, 8'h3C);
        @(negedge clock);
        opcode = OP_OR; start = 1'b1;
        @(posedge clock); #1;
        check("b2b_or", {15'b0, done, alu_result}, {15'b0, 1'b1, 16'h003F});
        opcode = OP_AND;
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_and", {12'b0, done, flags_out, alu_result}, {12'b0, 1'b1, 3'b000, 16'h000C});
        @(posedge clock); #1;
        check("b2b_pulse", {31'b0, done}, 32'b0);

        for (int i = 0; i < 30; i++) begin
            do_op(3'($urandom), 8'($urandom), 8'($urandom), 1'b1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
